dac_playback_sequencer: RTL and testbench
=========================================

DAC_PLAYBACK_SEQUENCER -- requirements
Module: dac_playback_sequencer

Interface
REQ-001 Parameters (name, default, meaning): DAC_WIDTH, 10, sample width; ADDR_WIDTH, 10, sample memory word address width; DIV_WIDTH, 16, rate divider width; WAKE_CYCLES, 16, power-up settling cycles.
REQ-002 Ports (name, direction, width, meaning): SPLB_Clk, in, 1, sole clock; SPLB_Resetn, in, 1, reset, asynchronous, active-low.
REQ-003 cfg_start, in, 1, single-cycle start pulse; cfg_stop, in, 1, single-cycle stop pulse; cfg_loop, in, 1, loop enable.
REQ-004 cfg_start_addr, in, ADDR_WIDTH, first sample address; cfg_end_addr, in, ADDR_WIDTH, last sample address (inclusive); cfg_rate_div, in, DIV_WIDTH, sample period minus one, in clocks.
REQ-005 mem_rd_en, out, 1, read strobe; mem_addr, out, ADDR_WIDTH, read address; mem_rd_data, in, DAC_WIDTH, data valid exactly 1 cycle after mem_rd_en.
REQ-006 S_Data, out, DAC_WIDTH, DAC sample; S_DCLKIO, out, 1, one-cycle strobe when S_Data updates; S_PWRDN, out, 1, DAC power-down; S_OpEnI, out, 1, I-channel enable; S_OpEnQ, out, 1, Q-channel enable.
REQ-007 busy, out, 1, high in any state except IDLE; done, out, 1, one-cycle pulse on non-loop completion or stop; cfg_err, out, 1, one-cycle pulse on rejected start.

Function
REQ-008 States SHALL be IDLE, WAKE, RUN, STOP; encoding is implementer's choice.
REQ-009 IDLE: on cfg_start, if cfg_end_addr >= cfg_start_addr, latch start/end/rate/loop and enter WAKE; otherwise pulse cfg_err next cycle and remain in IDLE.
REQ-010 WAKE: S_PWRDN low; count WAKE_CYCLES clocks, then enter RUN with divider counter at 0 and mem_addr at latched start.
REQ-011 RUN: divider counts 0..rate_div; when it equals 0, assert mem_rd_en for one cycle at current mem_addr.
REQ-012 Sample latency: S_Data SHALL take mem_rd_data and S_DCLKIO SHALL pulse on the cycle after mem_rd_en (1-cycle read latency + register = S_Data valid 2 cycles after the tick).
REQ-013 rate_div = 0 SHALL give one sample per clock; period is always rate_div+1 clocks.
REQ-014 Address advance: after each read, mem_addr increments; at latched end address, wrap to latched start if loop, otherwise enter STOP after the final read's S_DCLKIO.
REQ-015 A single-sample program (start == end) SHALL output exactly one sample when loop=0, and repeat it every period when loop=1.
REQ-016 STOP: hold S_Data at last value, deassert S_OpEnI/S_OpEnQ, assert S_PWRDN, pulse done, return to IDLE next cycle.
REQ-017 cfg_stop in WAKE or RUN SHALL enter STOP on the next cycle; an in-flight read's data is discarded (no S_DCLKIO).
REQ-018 cfg_start while busy SHALL be ignored (no cfg_err); cfg_start and cfg_stop in the same cycle: stop wins; in IDLE both are ignored.
REQ-019 cfg_* changes after start SHALL NOT affect the running program except cfg_stop.

Reset
REQ-020 SPLB_Resetn low SHALL immediately force IDLE, mem_rd_en=0, mem_addr=0, S_Data=0, S_DCLKIO=0, S_PWRDN=1, S_OpEnI=0, S_OpEnQ=0, busy=0, done=0, cfg_err=0.
REQ-021 Reset mid-RUN SHALL abort without a done pulse; deassertion is synchronised to SPLB_Clk internally.

Configuration
REQ-022 Macro DAC_SEQ_IQ_INTERLEAVE_EN defined: in RUN, S_OpEnI high for samples read from even addresses, S_OpEnQ high for odd, updated with S_DCLKIO; never both high.
REQ-023 Macro undefined: S_OpEnI and S_OpEnQ both high from WAKE exit through RUN, low otherwise.

Verification
REQ-024 start=4, end=7, div=3, loop=0 -> 4 S_DCLKIO pulses 4 clocks apart with data mem[4..7], then done pulse, S_PWRDN=1.
REQ-025 start=0, end=1, div=0, loop=1 -> S_Data alternates mem[0],mem[1] every clock; cfg_stop -> STOP next cycle, done pulse, no further strobes.
REQ-026 start=9, end=3 -> cfg_err pulse, busy stays 0, mem_rd_en never asserted.
REQ-027 SPLB_Resetn low during RUN -> all outputs at REQ-020 values same cycle, no done; fresh start afterwards runs normally.
REQ-028 cfg_start and cfg_stop together during RUN -> STOP taken; second cfg_start during WAKE -> ignored, WAKE lasts 16 clocks.
REQ-029 With DAC_SEQ_IQ_INTERLEAVE_EN, start=2, end=5 -> S_OpEnI,S_OpEnQ sequence 10,01,10,01 aligned to strobes; without it both 1 throughout RUN.

Source files
------------

// File: rtl/dac_playback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dac_playback_sequencer
// Brief    : Plays a sample window from memory into a DAC at a programmable
//            rate, with power-up settling, looping and abort control.
//            Optional macro DAC_SEQ_IQ_INTERLEAVE_EN: even/odd addresses
//            drive the I/Q channel enables alternately.
// Revision : 1.0 - initial release
// ============================================================================
module dac_playback_sequencer #(
    parameter int DAC_WIDTH   = 10,
    parameter int ADDR_WIDTH  = 10,
    parameter int DIV_WIDTH   = 16,
    parameter int WAKE_CYCLES = 16
) (
    input  logic                  SPLB_Clk,
    input  logic                  SPLB_Resetn,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic                  cfg_loop,
    input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_end_addr,
    input  logic [DIV_WIDTH-1:0]  cfg_rate_div,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DAC_WIDTH-1:0]  mem_rd_data,
    output logic [DAC_WIDTH-1:0]  S_Data,
    output logic                  S_DCLKIO,
    output logic                  S_PWRDN,
    output logic                  S_OpEnI,
    output logic                  S_OpEnQ,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAKE = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int                  C_WAKE_W    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [C_WAKE_W-1:0] C_WAKE_LAST = C_WAKE_W'(WAKE_CYCLES - 1);

    logic [1:0]            r_rstSync;
    logic                  w_rstN;
    state_t                r_state;
    logic [C_WAKE_W-1:0]   r_wakeCnt;
    logic [ADDR_WIDTH-1:0] r_startAddr;
    logic [ADDR_WIDTH-1:0] r_endAddr;
    logic [DIV_WIDTH-1:0]  r_rateDiv;
    logic                  r_loop;
    logic [DIV_WIDTH-1:0]  r_divCnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rdEn;
    logic                  r_rdPend;
    logic                  r_finish;
    logic [DAC_WIDTH-1:0]  r_data;
    logic                  r_dclk;
    logic                  r_pwrdn;
    logic                  r_opEnI;
    logic                  r_opEnQ;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cfgErr;
`ifdef DAC_SEQ_IQ_INTERLEAVE_EN
    logic                  r_rdLsb;
`endif

    logic                  w_atEnd;
    logic                  w_finishNext;
    logic [DIV_WIDTH-1:0]  w_nextDiv;
    logic                  w_enterStop;

    // Reset asserts asynchronously, releases two clocks after SPLB_Resetn rises.
    always_ff @(posedge SPLB_Clk or negedge SPLB_Resetn) begin
        if (!SPLB_Resetn) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end
    assign w_rstN = r_rstSync[1];

    assign w_atEnd      = (r_addr == r_endAddr);
    assign w_finishNext = r_finish || (r_rdEn && w_atEnd && !r_loop);
    assign w_nextDiv    = (r_divCnt == r_rateDiv) ? '0 : r_divCnt + 1'b1;
    // The natural end waits for the final strobe: finish set, strobe out, nothing in flight.
    assign w_enterStop  = (((r_state == WAKE) || (r_state == RUN)) && cfg_stop) ||
                          ((r_state == RUN) && r_finish && r_dclk && !r_rdPend);

    always_ff @(posedge SPLB_Clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state     <= IDLE;
            r_wakeCnt   <= '0;
            r_startAddr <= '0;
            r_endAddr   <= '0;
            r_rateDiv   <= '0;
            r_loop      <= 1'b0;
            r_divCnt    <= '0;
            r_addr      <= '0;
            r_rdEn      <= 1'b0;
            r_rdPend    <= 1'b0;
            r_finish    <= 1'b0;
            r_data      <= '0;
            r_dclk      <= 1'b0;
            r_pwrdn     <= 1'b1;
            r_opEnI     <= 1'b0;
            r_opEnQ     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfgErr    <= 1'b0;
`ifdef DAC_SEQ_IQ_INTERLEAVE_EN
            r_rdLsb     <= 1'b0;
`endif
        end else begin
            r_done   <= 1'b0;
            r_cfgErr <= 1'b0;
            r_dclk   <= 1'b0;
            r_rdPend <= r_rdEn;
            if (w_enterStop) begin
                r_state <= STOP;
                r_rdEn  <= 1'b0;
                r_pwrdn <= 1'b1;
                r_opEnI <= 1'b0;
                r_opEnQ <= 1'b0;
                r_done  <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (cfg_start && !cfg_stop) begin
                            if (cfg_end_addr >= cfg_start_addr) begin
                                r_startAddr <= cfg_start_addr;
                                r_endAddr   <= cfg_end_addr;
                                r_rateDiv   <= cfg_rate_div;
                                r_loop      <= cfg_loop;
                                r_wakeCnt   <= '0;
                                r_pwrdn     <= 1'b0;
                                r_busy      <= 1'b1;
                                r_state     <= WAKE;
                            end else begin
                                r_cfgErr <= 1'b1;
                            end
                        end
                    end
                    WAKE: begin
                        if (r_wakeCnt == C_WAKE_LAST) begin
                            r_state  <= RUN;
                            r_divCnt <= '0;
                            r_addr   <= r_startAddr;
                            r_rdEn   <= 1'b1;
                            r_finish <= 1'b0;
`ifdef DAC_SEQ_IQ_INTERLEAVE_EN
                            r_opEnI  <= 1'b0;
                            r_opEnQ  <= 1'b0;
`else
                            r_opEnI  <= 1'b1;
                            r_opEnQ  <= 1'b1;
`endif
                        end else begin
                            r_wakeCnt <= r_wakeCnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (r_rdPend) begin
                            r_data <= mem_rd_data;
                            r_dclk <= 1'b1;
`ifdef DAC_SEQ_IQ_INTERLEAVE_EN
                            r_opEnI <= ~r_rdLsb;
                            r_opEnQ <= r_rdLsb;
`endif
                        end
                        if (r_rdEn) begin
`ifdef DAC_SEQ_IQ_INTERLEAVE_EN
                            r_rdLsb <= r_addr[0];
`endif
                            if (w_atEnd) begin
                                if (r_loop) begin
                                    r_addr <= r_startAddr;
                                end
                            end else begin
                                r_addr <= r_addr + 1'b1;
                            end
                        end
                        r_finish <= w_finishNext;
                        r_divCnt <= w_nextDiv;
                        r_rdEn   <= (w_nextDiv == '0) && !w_finishNext;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_rd_en = r_rdEn;
    assign mem_addr  = r_addr;
    assign S_Data    = r_data;
    assign S_DCLKIO  = r_dclk;
    assign S_PWRDN   = r_pwrdn;
    assign S_OpEnI   = r_opEnI;
    assign S_OpEnQ   = r_opEnQ;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfgErr;

endmodule
`default_nettype wire

// File: tb/tb_dac_playback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_playback_sequencer
// Brief    : Randomised bench with a cycle-arithmetic playback model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_playback_sequencer;

    localparam int DW    = 10;
    localparam int AW    = 10;
    localparam int VW    = 16;
    localparam int W     = 16;
    localparam int LIMIT = 5000;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          cfg_start = 1'b0, cfg_stop = 1'b0, cfg_loop = 1'b0;
    logic [AW-1:0] cfg_start_addr = '0, cfg_end_addr = '0;
    logic [VW-1:0] cfg_rate_div = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] S_Data;
    logic          S_DCLKIO, S_PWRDN, S_OpEnI, S_OpEnQ, busy, done, cfg_err;

    dac_playback_sequencer #(
        .DAC_WIDTH(DW), .ADDR_WIDTH(AW), .DIV_WIDTH(VW), .WAKE_CYCLES(W)
    ) dut (
        .SPLB_Clk(clk), .SPLB_Resetn(rstn),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_loop(cfg_loop),
        .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
        .cfg_rate_div(cfg_rate_div),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .S_Data(S_Data), .S_DCLKIO(S_DCLKIO), .S_PWRDN(S_PWRDN),
        .S_OpEnI(S_OpEnI), .S_OpEnQ(S_OpEnQ),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Sample memory: data appears exactly one clock after a read, noise otherwise.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : DW'($urandom);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nTests = 0, nFail = 0;
    bit checkEn = 1'b0;

    // Program model: everything is derived from launch cycle and parameters.
    bit mValid = 1'b0, mLoop = 1'b0;
    int mT0 = -100, mS = 0, mE = 0, mD = 0, mStopC = -100, mErrCycle = -10;
    int expData = 0;
    bit saw = 1'b0, par = 1'b0;

    int strobeCyc[$], strobeDat[$], iqPat[$], doneCyc[$], rdCyc[$];
    int errCnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int runStart();
        return mT0 + 1 + W;
    endfunction

    function automatic int natStop();
        if (mLoop) return 1 << 30;
        return runStart() + (mE - mS) * (mD + 1) + 3;
    endfunction

    function automatic bit tickAt(input int c, output int a);
        int k, n;
        a = 0;
        if (!mValid || c < runStart() || c >= mStopC) return 1'b0;
        k = c - runStart();
        if (k % (mD + 1) != 0) return 1'b0;
        k = k / (mD + 1);
        n = mE - mS + 1;
        if (!mLoop && k >= n) return 1'b0;
        a = mS + k % n;
        return 1'b1;
    endfunction

    int  c, a, a2;
    bit  tk, st, run, bsy;
    always @(negedge clk) begin
        if (checkEn) begin
            c   = cyc;
            tk  = tickAt(c, a);
            st  = tickAt(c - 2, a2) && (c < mStopC);
            bsy = mValid && (c >= mT0 + 1) && (c <= mStopC);
            run = mValid && (c >= runStart()) && (c < mStopC);
            if (c == mT0 + 1) saw = 1'b0;
            if (st) begin
                expData = int'(mem[a2]);
                saw     = 1'b1;
                par     = a2[0];
            end
            chk("busy", int'(busy), int'(bsy));
            chk("done", int'(done), int'(mValid && c == mStopC));
            chk("S_PWRDN", int'(S_PWRDN), int'(!(mValid && c >= mT0 + 1 && c < mStopC)));
            chk("mem_rd_en", int'(mem_rd_en), int'(tk));
            if (tk) chk("mem_addr", int'(mem_addr), a);
            chk("S_DCLKIO", int'(S_DCLKIO), int'(st));
            chk("S_Data", int'(S_Data), expData);
            chk("cfg_err", int'(cfg_err), int'(c == mErrCycle));
`ifdef DAC_SEQ_IQ_INTERLEAVE_EN
            chk("S_OpEnI", int'(S_OpEnI), int'(run && saw && !par));
            chk("S_OpEnQ", int'(S_OpEnQ), int'(run && saw && par));
`else
            chk("S_OpEnI", int'(S_OpEnI), int'(run));
            chk("S_OpEnQ", int'(S_OpEnQ), int'(run));
`endif
            if (S_DCLKIO) begin
                strobeCyc.push_back(c);
                strobeDat.push_back(int'(S_Data));
                iqPat.push_back(int'({S_OpEnI, S_OpEnQ}));
            end
            if (done) doneCyc.push_back(c);
            if (mem_rd_en) rdCyc.push_back(c);
            if (cfg_err) errCnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        cfg_start_addr = AW'($urandom);
        cfg_end_addr   = AW'($urandom);
        cfg_rate_div   = VW'($urandom_range(0, 7));
        cfg_loop       = 1'($urandom);
    endtask

    task automatic beginProg(input int s, input int e, input int d, input bit lp, input bit idleCombo);
        step();
        cfg_start_addr = AW'(s);
        cfg_end_addr   = AW'(e);
        cfg_rate_div   = VW'(d);
        cfg_loop       = lp;
        cfg_start      = 1'b1;
        cfg_stop       = idleCombo;
        mT0 = cyc; mS = s; mE = e; mD = d; mLoop = lp;
        mValid    = (e >= s) && !idleCombo;
        mErrCycle = (e < s && !idleCombo) ? cyc + 1 : -10;
        mStopC    = mValid ? natStop() : -100;
    endtask

    task automatic runOut(input int stopAfter, input bit extraStart, input bit startWithStop);
        int guard = 0;
        do begin
            step();
            guard++;
            cfg_start = 1'b0;
            cfg_stop  = 1'b0;
            scramble();
            if (extraStart && cyc == mT0 + 5) cfg_start = 1'b1;
            if (stopAfter > 0 && cyc == mT0 + stopAfter) begin
                cfg_stop  = 1'b1;
                cfg_start = startWithStop;
                if (mValid && cyc < mStopC) mStopC = cyc + 1;
            end
        end while (cyc <= (mValid ? mStopC : mT0 + 2) + 1 && guard < LIMIT);
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        if (guard >= LIMIT) begin
            nTests++;
            nFail++;
            $display("FAIL timeout: program from cycle %0d still running after %0d cycles", mT0, guard);
        end
    endtask

    task automatic launch(input int s, input int e, input int d, input bit lp,
                          input int stopAfter, input bit extraStart, input bit startWithStop);
        beginProg(s, e, d, lp, 1'b0);
        runOut(stopAfter, extraStart, startWithStop);
    endtask

    task automatic chkReset(input string tag);
        chk({tag, " mem_rd_en"}, int'(mem_rd_en), 0);
        chk({tag, " mem_addr"}, int'(mem_addr), 0);
        chk({tag, " S_Data"}, int'(S_Data), 0);
        chk({tag, " S_DCLKIO"}, int'(S_DCLKIO), 0);
        chk({tag, " S_PWRDN"}, int'(S_PWRDN), 1);
        chk({tag, " S_OpEnI"}, int'(S_OpEnI), 0);
        chk({tag, " S_OpEnQ"}, int'(S_OpEnQ), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " cfg_err"}, int'(cfg_err), 0);
    endtask

    initial begin
        int i0, d0, r0, e0, t0, n, s, e, lp, sa;
        int expIq[4];
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);

        #1 rstn = 1'b0;
        #11 chkReset("reset");
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        repeat (4) step();
        checkEn = 1'b1;

        // Four samples, period 4, no loop
        i0 = strobeCyc.size(); d0 = doneCyc.size();
        launch(4, 7, 3, 1'b0, 0, 1'b0, 1'b0);
        t0 = mT0;
        chk("r024 strobes", strobeCyc.size() - i0, 4);
        chk("r024 done count", doneCyc.size() - d0, 1);
        if (strobeCyc.size() - i0 == 4 && doneCyc.size() - d0 == 1) begin
            chk("r024 first strobe", strobeCyc[i0], t0 + 19);
            for (int k = 0; k < 4; k++) begin
                chk("r024 data", strobeDat[i0 + k], int'(mem[4 + k]));
                if (k > 0) chk("r024 spacing", strobeCyc[i0 + k] - strobeCyc[i0 + k - 1], 4);
            end
            chk("r024 done cycle", doneCyc[d0], t0 + 32);
        end

        // Two-sample loop at full rate, then stop
        i0 = strobeCyc.size(); d0 = doneCyc.size();
        launch(0, 1, 0, 1'b1, 30, 1'b0, 1'b0);
        t0 = mT0;
        chk("r025 strobes", strobeCyc.size() - i0, 12);
        if (strobeCyc.size() - i0 == 12 && doneCyc.size() - d0 == 1) begin
            for (int k = 0; k < 12; k++) begin
                chk("r025 data", strobeDat[i0 + k], int'(mem[k % 2]));
                chk("r025 cycle", strobeCyc[i0 + k], t0 + 19 + k);
            end
            chk("r025 done cycle", doneCyc[d0], t0 + 31);
        end

        // Inverted range and start+stop in IDLE
        e0 = errCnt; r0 = rdCyc.size();
        launch(9, 3, 0, 1'b0, 0, 1'b0, 1'b0);
        chk("r026 cfg_err count", errCnt - e0, 1);
        chk("r026 no reads", rdCyc.size() - r0, 0);
        e0 = errCnt;
        beginProg(9, 3, 0, 1'b0, 1'b1);
        runOut(0, 1'b0, 1'b0);
        beginProg(4, 8, 0, 1'b0, 1'b1);
        runOut(0, 1'b0, 1'b0);
        chk("idle start+stop ignored", errCnt - e0, 0);
        chk("idle start+stop no reads", rdCyc.size() - r0, 0);

        // Second start during WAKE, then start+stop together in RUN
        r0 = rdCyc.size(); d0 = doneCyc.size();
        launch(10, 20, 2, 1'b0, 40, 1'b1, 1'b1);
        t0 = mT0;
        if (rdCyc.size() > r0 && doneCyc.size() > d0) begin
            chk("r028 first read", rdCyc[r0], t0 + 17);
            chk("r028 done cycle", doneCyc[d0], t0 + 41);
        end else begin
            chk("r028 activity", 0, 1);
        end

        // Reset during RUN, then a fresh program
        d0 = doneCyc.size();
        beginProg(100, 110, 1, 1'b1, 1'b0);
        step();
        cfg_start = 1'b0;
        repeat (23) step();
        checkEn = 1'b0;
        #2 rstn = 1'b0;
        #1 chkReset("reset mid-run");
        mValid = 1'b0; mErrCycle = -10; expData = 0; saw = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        repeat (3) step();
        checkEn = 1'b1;
        chk("r027 no done", doneCyc.size() - d0, 0);
        i0 = strobeCyc.size();
        launch(20, 23, 1, 1'b0, 0, 1'b0, 1'b0);
        chk("r027 fresh strobes", strobeCyc.size() - i0, 4);

        // Single-sample programs
        i0 = strobeCyc.size();
        launch(300, 300, 2, 1'b0, 0, 1'b0, 1'b0);
        chk("single noloop strobes", strobeCyc.size() - i0, 1);
        i0 = strobeCyc.size();
        launch(300, 300, 2, 1'b1, 40, 1'b0, 1'b0);
        chk("single loop strobes", strobeCyc.size() - i0, 8);

        // Channel-enable pattern across an even/odd window
`ifdef DAC_SEQ_IQ_INTERLEAVE_EN
        expIq = '{2, 1, 2, 1};
`else
        expIq = '{3, 3, 3, 3};
`endif
        i0 = iqPat.size();
        launch(2, 5, 1, 1'b0, 0, 1'b0, 1'b0);
        chk("r029 strobes", iqPat.size() - i0, 4);
        if (iqPat.size() - i0 == 4)
            for (int k = 0; k < 4; k++) chk("r029 IQ", iqPat[i0 + k], expIq[k]);

        // Top of address space with wrap
        launch(1020, 1023, 0, 1'b1, 30, 1'b0, 1'b0);

        // Randomised programs
        for (int p = 0; p < 14; p++) begin
            s  = $urandom_range(0, (1 << AW) - 1);
            n  = $urandom_range(0, 6);
            e  = ($urandom_range(0, 7) == 0) ? s - 1 : s + n;
            if (e > (1 << AW) - 1) e = (1 << AW) - 1;
            if (e < 0) e = 0;
            lp = $urandom_range(0, 1);
            sa = (lp != 0 || $urandom_range(0, 1) != 0) ? $urandom_range(3, 60) : 0;
            launch(s, e, $urandom_range(0, 4), 1'(lp), sa,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
